// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary conversion and depth calculation.
// Functions work on the widest legal pointer; callers cast to their own width.
package fifo_pkg;

    localparam int unsigned PTR_MAXW = 13;

    typedef logic [PTR_MAXW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Fold from the MSB down; zero-extended upper bits leave the result unchanged.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = int'(PTR_MAXW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned ptr_width);
        return 32'(1) << ptr_width;
    endfunction

endpackage

// File: rtl/wrptr_ctrl_if.sv
// Write-side pointer controller bus: write request, read pointer in, pointers and flags out.
interface wrptr_ctrl_if #(
    parameter int unsigned PTR_WIDTH = 3
);

    logic                 wr_en;
    logic [PTR_WIDTH:0]   g_rdptr;
    logic                 ovf_clr;
    logic                 wr_accept;
    logic [PTR_WIDTH-1:0] wr_addr;
    logic [PTR_WIDTH:0]   b_wrptr;
    logic [PTR_WIDTH:0]   g_wrptr;
    logic                 fifo_full;
    logic                 almost_full;
    logic [PTR_WIDTH:0]   wr_count;
    logic                 overflow;

    modport master (
        output wr_en, g_rdptr, ovf_clr,
        input  wr_accept, wr_addr, b_wrptr, g_wrptr, fifo_full, almost_full, wr_count, overflow
    );

    modport slave (
        input  wr_en, g_rdptr, ovf_clr,
        output wr_accept, wr_addr, b_wrptr, g_wrptr, fifo_full, almost_full, wr_count, overflow
    );

endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing into this clock domain.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wrptr_ctrl.sv
// Write-domain pointer controller: pointers, fill level, full/almost-full and sticky overflow.
// Flags are computed from the next write pointer so they track an accepted write at the same edge.
module wrptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 6
) (
    input  logic         wrclk,
    input  logic         wrrst_n,
    wrptr_ctrl_if.slave  bus
);

    localparam int unsigned PW1 = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] g_rdptr_sync;
    logic [PTR_WIDTH:0] b_rdptr_sync;
    logic [PTR_WIDTH:0] b_wrptr_q;
    logic [PTR_WIDTH:0] g_wrptr_q;
    logic [PTR_WIDTH:0] wr_count_q;
    logic               fifo_full_q;
    logic               almost_full_q;
    logic               overflow_q;

    logic               wr_accept_c;
    logic [PTR_WIDTH:0] b_wrptr_next;
    logic [PTR_WIDTH:0] g_wrptr_next;
    logic [PTR_WIDTH:0] level_next;
    logic [PTR_WIDTH:0] full_ptr;
    logic               full_next;
    logic               af_next;
    logic               ovf_next;

    ptr_sync #(
        .WIDTH  (PW1),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk   (wrclk),
        .rst_n (wrrst_n),
        .d     (bus.g_rdptr),
        .q     (g_rdptr_sync)
    );

    // Full when the write pointer is a whole lap ahead: top two Gray bits inverted.
    always_comb begin
        wr_accept_c  = bus.wr_en & ~fifo_full_q;
        b_wrptr_next = b_wrptr_q + PW1'(wr_accept_c);
        g_wrptr_next = PW1'(bin2gray(PTR_MAXW'(b_wrptr_next)));
        b_rdptr_sync = PW1'(gray2bin(PTR_MAXW'(g_rdptr_sync)));
        level_next   = b_wrptr_next - b_rdptr_sync;
        full_ptr     = {~g_rdptr_sync[PTR_WIDTH -: 2], g_rdptr_sync[PTR_WIDTH-2:0]};
        full_next    = (g_wrptr_next == full_ptr);
        af_next      = (level_next >= PW1'(AF_LEVEL));
        ovf_next     = overflow_q;
        if (bus.wr_en && fifo_full_q) begin
            ovf_next = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge wrclk) begin
        if (!wrrst_n) begin
            b_wrptr_q     <= '0;
            g_wrptr_q     <= '0;
            wr_count_q    <= '0;
            fifo_full_q   <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            b_wrptr_q     <= b_wrptr_next;
            g_wrptr_q     <= g_wrptr_next;
            wr_count_q    <= level_next;
            fifo_full_q   <= full_next;
            almost_full_q <= af_next;
            overflow_q    <= ovf_next;
        end
    end

    assign bus.wr_accept   = wr_accept_c;
    assign bus.wr_addr     = b_wrptr_q[PTR_WIDTH-1:0];
    assign bus.b_wrptr     = b_wrptr_q;
    assign bus.g_wrptr     = g_wrptr_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.fifo_full   = fifo_full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_wrptr_ctrl.sv
// Directed bench for wrptr_ctrl: fill, overflow, read release, wrap-around, reset and width sweep.
module tb_wrptr_ctrl;

    logic wrclk = 1'b0;
    logic wrrst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 wrclk = ~wrclk;

    wrptr_ctrl_if #(.PTR_WIDTH(3)) if0 ();
    wrptr_ctrl_if #(.PTR_WIDTH(2)) if1 ();
    wrptr_ctrl_if #(.PTR_WIDTH(5)) if2 ();

    wrptr_ctrl #(.PTR_WIDTH(3), .SYNC_STAGES(2), .AF_LEVEL(6))
        u0 (.wrclk(wrclk), .wrrst_n(wrrst_n), .bus(if0));
    wrptr_ctrl #(.PTR_WIDTH(2), .SYNC_STAGES(3), .AF_LEVEL(4))
        u1 (.wrclk(wrclk), .wrrst_n(wrrst_n), .bus(if1));
    wrptr_ctrl #(.PTR_WIDTH(5), .SYNC_STAGES(3), .AF_LEVEL(32))
        u2 (.wrclk(wrclk), .wrrst_n(wrrst_n), .bus(if2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    function automatic logic [3:0] g2b4(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_bptr"}, 32'(if0.b_wrptr), 32'd0);
        check({tag, "_gptr"}, 32'(if0.g_wrptr), 32'd0);
        check({tag, "_cnt"},  32'(if0.wr_count), 32'd0);
        check({tag, "_full"}, 32'(if0.fifo_full), 32'd0);
        check({tag, "_af"},   32'(if0.almost_full), 32'd0);
        check({tag, "_ovf"},  32'(if0.overflow), 32'd0);
        check({tag, "_addr"}, 32'(if0.wr_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wb, rb, nb, s0, s1, lvl, prev_g, gr, diff;
        logic       e_full, acc;
        int         n_wr, cyc, acc1, acc2;

        wrrst_n = 1'b0;
        if0.wr_en = 1'b0; if0.ovf_clr = 1'b0; if0.g_rdptr = '0;
        if1.wr_en = 1'b0; if1.ovf_clr = 1'b0; if1.g_rdptr = '0;
        if2.wr_en = 1'b0; if2.ovf_clr = 1'b0; if2.g_rdptr = '0;
        tick();
        tick();
        check_zero("rst");
        check("rst_acc", 32'(if0.wr_accept), 32'd0);
        wrrst_n = 1'b1;

        // Fill eight entries with the read pointer parked at zero
        if0.wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1 check("fill_acc", 32'(if0.wr_accept), 32'd1);
            tick();
            check("fill_cnt",  32'(if0.wr_count), 32'(i));
            check("fill_af",   32'(if0.almost_full), 32'(i >= 6));
            check("fill_full", 32'(if0.fifo_full), 32'(i == 8));
            check("fill_bptr", 32'(if0.b_wrptr), 32'(i));
        end
        check("full_bptr", 32'(if0.b_wrptr), 32'h8);
        check("full_gptr", 32'(if0.g_wrptr), 32'hC);

        // Writes while full are dropped and flag overflow
        for (int i = 0; i < 3; i++) begin
            #1 check("ovf_acc", 32'(if0.wr_accept), 32'd0);
            tick();
            check("ovf_bptr", 32'(if0.b_wrptr), 32'h8);
            check("ovf_gptr", 32'(if0.g_wrptr), 32'hC);
            check("ovf_set",  32'(if0.overflow), 32'd1);
        end
        if0.wr_en = 1'b0; if0.ovf_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(if0.overflow), 32'd0);
        if0.wr_en = 1'b1;
        tick();
        check("ovf_set_wins", 32'(if0.overflow), 32'd1);
        check("ovf_hold_bptr", 32'(if0.b_wrptr), 32'h8);
        if0.wr_en = 1'b0;
        tick();
        check("ovf_clr2", 32'(if0.overflow), 32'd0);
        if0.ovf_clr = 1'b0;

        // Read side advances to 3: flags follow SYNC_STAGES+1 edges later
        if0.g_rdptr = 4'b0010;
        tick();
        tick();
        check("rel_full_hold", 32'(if0.fifo_full), 32'd1);
        check("rel_cnt_hold",  32'(if0.wr_count), 32'd8);
        tick();
        check("rel_full", 32'(if0.fifo_full), 32'd0);
        check("rel_cnt",  32'(if0.wr_count), 32'd5);
        check("rel_af",   32'(if0.almost_full), 32'd0);

        // Wrap-around stream against an occupancy model of the pipeline
        if0.g_rdptr = '0;
        wrrst_n = 1'b0;
        tick();
        wrrst_n = 1'b1;
        wb = '0; rb = '0; s0 = '0; s1 = '0; e_full = 1'b0; prev_g = '0;
        n_wr = 0; cyc = 0;
        if0.wr_en = 1'b1;
        while (n_wr < 40 && cyc < 200) begin
            diff = wb - rb;
            if ((cyc % 2) == 0 && diff != 4'd0) rb = rb + 4'd1;
            gr = rb ^ (rb >> 1);
            if0.g_rdptr = gr;
            #1 check("wrap_acc", 32'(if0.wr_accept), 32'(!e_full));
            acc    = !e_full;
            nb     = wb + 4'(acc);
            lvl    = nb - g2b4(s1);
            e_full = (lvl == 4'd8);
            s1     = s0;
            s0     = gr;
            wb     = nb;
            n_wr   = n_wr + int'(acc);
            tick();
            check("wrap_full", 32'(if0.fifo_full), 32'(e_full));
            check("wrap_cnt",  32'(if0.wr_count), 32'(lvl));
            check("wrap_bptr", 32'(if0.b_wrptr), 32'(wb));
            check("wrap_gptr", 32'(if0.g_wrptr), 32'(wb ^ (wb >> 1)));
            check("wrap_gray1", 32'($countones(if0.g_wrptr ^ prev_g) <= 1), 32'd1);
            check("wrap_msb",  32'(if0.b_wrptr[3]), 32'((n_wr / 8) % 2));
            prev_g = if0.g_wrptr;
            cyc++;
        end
        check("wrap_done", 32'(n_wr), 32'd40);
        if0.wr_en = 1'b0;

        // Reset in the middle of a write burst
        if0.g_rdptr = '0;
        wrrst_n = 1'b0;
        tick();
        wrrst_n = 1'b1;
        if0.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_cnt5", 32'(if0.wr_count), 32'd5);
        wrrst_n = 1'b0;
        tick();
        check_zero("mid_rst");
        wrrst_n = 1'b1;
        tick();
        check("mid_resume_cnt",  32'(if0.wr_count), 32'd1);
        check("mid_resume_bptr", 32'(if0.b_wrptr), 32'd1);
        if0.wr_en = 1'b0;

        // Width sweep with AF_LEVEL at full depth
        wrrst_n = 1'b0;
        tick();
        wrrst_n = 1'b1;
        if1.wr_en = 1'b1;
        if2.wr_en = 1'b1;
        acc1 = 0;
        acc2 = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            acc1 += int'(if1.wr_accept);
            acc2 += int'(if2.wr_accept);
            tick();
            check("sw1_af_eq_full", 32'(if1.almost_full), 32'(if1.fifo_full));
            check("sw2_af_eq_full", 32'(if2.almost_full), 32'(if2.fifo_full));
        end
        check("sw1_accepts", 32'(acc1), 32'(fifo_pkg::fifo_depth(2)));
        check("sw2_accepts", 32'(acc2), 32'(fifo_pkg::fifo_depth(5)));
        check("sw1_full", 32'(if1.fifo_full), 32'd1);
        check("sw2_full", 32'(if2.fifo_full), 32'd1);
        check("sw1_cnt",  32'(if1.wr_count), 32'd4);
        check("sw2_cnt",  32'(if2.wr_count), 32'd32);
        if1.wr_en = 1'b0;
        if2.wr_en = 1'b0;
        if1.g_rdptr = 3'b001;
        if2.g_rdptr = 6'b000001;
        tick();
        tick();
        tick();
        check("sw1_lat_hold", 32'(if1.fifo_full), 32'd1);
        check("sw2_lat_hold", 32'(if2.fifo_full), 32'd1);
        tick();
        check("sw1_lat_full", 32'(if1.fifo_full), 32'd0);
        check("sw2_lat_full", 32'(if2.fifo_full), 32'd0);
        check("sw1_lat_af",   32'(if1.almost_full), 32'd0);
        check("sw2_lat_af",   32'(if2.almost_full), 32'd0);
        check("sw1_lat_cnt",  32'(if1.wr_count), 32'd3);
        check("sw2_lat_cnt",  32'(if2.wr_count), 32'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
